// File: rtl/vga_scan_timing.sv
// vga_scan_timing: 640x480@60 raster generator and VGA DAC driver.
// Produces renderer coordinates (x, y), then registers the returned colour
// together with sync/blank so every DAC output lags x/y by one pixel period.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   x, y                current pixel column/row (0 while blanked)
//   r_in, g_in, b_in    colour returned by the renderer mux
//   vga_r/g/b           colour to the DAC (0 while blanked)
//   vga_hs, vga_vs      syncs, asserted level set by SYNC_POL
//   vga_blank_n         high while the output pixel is visible
//   vga_clk             pixel clock to the DAC
//   frame_start         one-clk pulse at pixel (0,0)
//   test_mode           colour-bar override (VGA_TEST_PATTERN_EN only)
//
// Optional build macro VGA_TEST_PATTERN_EN adds test_mode and an eight-bar
// colour pattern (white, yellow, cyan, green, magenta, red, blue, black).
module vga_scan_timing #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       test_mode,
`endif
    output logic [9:0] x,
    output logic [8:0] y,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_clk,
    output logic       frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW    = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);

    localparam logic SYNC_ON = (SYNC_POL != 0);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic [9:0]    h_nxt;
    logic [9:0]    v_nxt;
    logic          pix_en;
    logic          visible;
    logic          hs_on;
    logic          vs_on;
    logic [7:0]    r_sel;
    logic [7:0]    g_sel;
    logic [7:0]    b_sel;

    always_comb begin
        pix_en  = (div_cnt == DIV_LAST);
        div_nxt = pix_en ? '0 : div_cnt + 1'b1;
        h_nxt   = h_cnt;
        v_nxt   = v_cnt;
        if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_nxt = h_cnt + 10'd1;
            end
        end
        // These decode the pixel just presented on x/y, which becomes
        // the DAC pixel at this pix_en.
        visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_on   = (h_cnt >= H_SS) && (h_cnt < H_SE);
        vs_on   = (v_cnt >= V_SS) && (v_cnt < V_SE);
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

    logic [2:0] bar;

    // Bar index bits map directly to inverted channel enables.
    always_comb begin
        bar   = 3'(h_cnt / BAR_W);
        r_sel = r_in;
        g_sel = g_in;
        b_sel = b_in;
        if (test_mode) begin
            r_sel = {8{~bar[1]}};
            g_sel = {8{~bar[2]}};
            b_sel = {8{~bar[0]}};
        end
    end
`else
    assign r_sel = r_in;
    assign g_sel = g_in;
    assign b_sel = b_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            x           <= '0;
            y           <= '0;
            vga_clk     <= 1'b0;
            frame_start <= 1'b0;
            vga_hs      <= ~SYNC_ON;
            vga_vs      <= ~SYNC_ON;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            div_cnt     <= div_nxt;
            vga_clk     <= (div_nxt >= DIV_HALF);
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            x           <= (h_nxt < H_VIS) ? h_nxt : '0;
            y           <= (v_nxt < V_VIS) ? v_nxt[8:0] : '0;
            frame_start <= pix_en && (h_cnt == '0) && (v_cnt == '0);
            if (pix_en) begin
                vga_hs      <= hs_on ? SYNC_ON : ~SYNC_ON;
                vga_vs      <= vs_on ? SYNC_ON : ~SYNC_ON;
                vga_blank_n <= visible;
                vga_r       <= visible ? r_sel : '0;
                vga_g       <= visible ? g_sel : '0;
                vga_b       <= visible ? b_sel : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_timing.sv
// tb_vga_scan_timing: random-colour raster check of vga_scan_timing.
// Full-width lines with a short frame so two frames fit in the run.
module tb_vga_scan_timing;

    localparam int D   = 2;
    localparam int HA  = 640;
    localparam int HFP = 16;
    localparam int HS  = 96;
    localparam int HBP = 48;
    localparam int VA  = 10;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FR  = HT * VT;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r_in, g_in, b_in;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_clk, frame_start;

    vga_scan_timing #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(0)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .x(x), .y(y), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_clk(vga_clk), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Edges since reset release and the colour seen at the latest pixel edge.
    int          t;
    logic [23:0] cap;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t   = 0;
            cap = '0;
        end else begin
            t = t + 1;
            if (t % D == 0) cap = {r_in, g_in, b_in};
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int prints = 0;

    logic hold_ok = 1'b0;
    logic done = 1'b0;
    logic fin = 1'b0;
    int   timeouts = 0;

    int cyc = 0;
    int fs_last = -1, fs_period = -1;
    int hs_fall = -1, hs_rise = -1, vs_fall = -1, vs_rise = -1;
    logic prev_hs = 1'b1, prev_vs = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0d", nm, act, exp, t);
        end
    endtask

    int P, dv, p, q, hq, vq, ex, ey;
    logic ehs, evs, ebl, eck, efs;
    logic [23:0] ec;
    logic [47:0] got, exp_v;

    always @(negedge clk) begin
        cyc++;
        got = {x, y, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n,
               vga_clk, frame_start};
        if (rst) begin
            chk("reset_values", got, {10'd0, 9'd0, 24'd0, 5'b11000});
        end else begin
            P  = t / D;
            dv = t % D;
            p  = P % FR;
            ex = (p % HT < HA) ? p % HT : 0;
            ey = (p / HT < VA) ? p / HT : 0;
            if (P == 0) begin
                ehs = 1'b1; evs = 1'b1; ebl = 1'b0; ec = '0; efs = 1'b0;
            end else begin
                q   = (P - 1) % FR;
                hq  = q % HT;
                vq  = q / HT;
                ehs = !(hq >= HA + HFP && hq < HA + HFP + HS);
                evs = !(vq >= VA + VFP && vq < VA + VFP + VS);
                ebl = (hq < HA) && (vq < VA);
                ec  = ebl ? cap : 24'd0;
                efs = (dv == 0) && (q == 0);
            end
            eck = (dv >= D / 2);
            exp_v = {10'(ex), 9'(ey), ec, ehs, evs, ebl, eck, efs};
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                if (prints < 20) begin
                    prints++;
                    $display("FAIL raster t=%0d: got %h expected %h",
                             t, got, exp_v);
                end
            end
            if (t == 1) chk("x_t1", {x, frame_start}, {10'd0, 1'b0});
            if (t == 2) chk("fs_t2", frame_start, 1'b1);
            if (t == 3) chk("x_t3", x, 10'd1);
            if (t == 5) chk("x_t5", x, 10'd2);
            if (hold_ok && vga_blank_n)
                chk("rgb_fixed", {vga_r, vga_g, vga_b}, 24'hAB1234);
            if (hold_ok && !vga_blank_n)
                chk("rgb_blank", {vga_r, vga_g, vga_b}, 24'h0);
            if (frame_start) begin
                if (fs_last >= 0 && fs_period < 0) fs_period = cyc - fs_last;
                fs_last = cyc;
            end
            if (prev_hs && !vga_hs && hs_fall < 0) hs_fall = t;
            if (!prev_hs && vga_hs && hs_fall >= 0 && hs_rise < 0) hs_rise = t;
            if (prev_vs && !vga_vs && vs_fall < 0) vs_fall = t;
            if (!prev_vs && vga_vs && vs_fall >= 0 && vs_rise < 0) vs_rise = t;
        end
        prev_hs = vga_hs;
        prev_vs = vga_vs;
        if (done && !fin) begin
            chk("fs_period", 64'(fs_period), 64'd27200);
            chk("hs_fall_t", 64'(hs_fall), 64'd1314);
            chk("hs_low_clks", 64'(hs_rise - hs_fall), 64'd192);
            chk("vs_fall_t", 64'(vs_fall), 64'd19202);
            chk("vs_low_clks", 64'(vs_rise - vs_fall), 64'd3200);
            chk("wait_timeout", 64'(timeouts), 64'd0);
            fin = 1'b1;
        end
    end

    logic hold = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (!hold) begin
            r_in = 8'($urandom);
            g_in = 8'($urandom);
            b_in = 8'($urandom);
        end
    endtask

    initial begin
        bit found;
        rst  = 1'b1;
        r_in = '0;
        g_in = '0;
        b_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * FR * D + 100) tick();
        hold = 1'b1;
        r_in = 8'hAB;
        g_in = 8'h12;
        b_in = 8'h34;
        repeat (4) tick();
        hold_ok = 1'b1;
        repeat (2000) tick();
        hold_ok = 1'b0;
        hold = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3 * FR * D; i++) begin
            tick();
            if (x == 10'd300 && y == 9'd5) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            timeouts++;
            $display("FAIL mid_frame_wait: got no (300,5) expected one");
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3000) tick();
        done = 1'b1;
        for (int i = 0; i < 10 && !fin; i++) @(negedge clk);
        #1;
        if (!fin) begin
            miscompares++;
            $display("FAIL final_checks: got none expected done");
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
